// File: rtl/ps2_key_pkg.sv
// Shared constants, key map and event types for the PS/2 key scanner.
package ps2_key_pkg;

    localparam logic [7:0] E0 = 8'hE0;
    localparam logic [7:0] F0 = 8'hF0;
    localparam logic [7:0] E1 = 8'hE1;

    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [1:0] {MUST0, MUST1, DONTCARE} ext_mode_e;

    typedef enum logic [2:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK, ST_PAUSE} dec_state_e;

    typedef struct packed {
        logic       used;
        logic [7:0] code;
        ext_mode_e  mode;
    } key_entry_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } key_evt_t;

    localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3, PLUS = 4;
    localparam int MINUS = 5, ENTER = 6, ESCAPE = 7, RESET = 8, PAUSE = 9;

    function automatic key_entry_t key_map(input int idx);
        case (idx)
            UP:      key_map = '{1'b1, 8'h75, DONTCARE};
            DOWN:    key_map = '{1'b1, 8'h72, DONTCARE};
            LEFT:    key_map = '{1'b1, 8'h6B, DONTCARE};
            RIGHT:   key_map = '{1'b1, 8'h74, DONTCARE};
            PLUS:    key_map = '{1'b1, 8'h55, MUST0};
            MINUS:   key_map = '{1'b1, 8'h4E, MUST0};
            ENTER:   key_map = '{1'b1, 8'h5A, DONTCARE};
            ESCAPE:  key_map = '{1'b1, 8'h76, MUST0};
            RESET:   key_map = '{1'b1, 8'h2D, MUST0};
            PAUSE:   key_map = '{1'b1, 8'hE1, MUST0};
            default: key_map = '{1'b0, 8'h00, MUST0};
        endcase
    endfunction

    function automatic logic key_match(input key_entry_t e, input logic [7:0] code,
                                       input logic ext);
        return e.used && (e.code == code) && ((e.mode == DONTCARE) || ((e.mode == MUST1) == ext));
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronisers, sample-tick divider, 11-bit shifter,
// start/stop/odd-parity check and partial-frame timeout.
module ps2_frame_rx #(
    parameter int CLK_DIV       = 250,
    parameter int TIMEOUT_TICKS = 4000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_vld_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          clk_prev_q;
    logic [DW-1:0] div_q;
    logic [10:0]   shift_q, shift_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [TW-1:0] to_q, to_d;
    logic          byte_vld_q, frame_err_q;
    logic [7:0]    byte_q;
    logic          tick, fall, frame_end, frame_ok;

    assign tick      = (div_q == '0);
    assign fall      = tick && clk_prev_q && !clk_sync_q[1];
    assign frame_end = fall && (cnt_q == 4'd10);
    // shift_d holds the complete frame (start at bit 0) when frame_end is high
    assign frame_ok  = !shift_d[0] && shift_d[10] && (^shift_d[9:1]);

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        if (fall) begin
            shift_d = {dat_sync_q[1], shift_q[10:1]};
            cnt_d   = frame_end ? 4'd0 : cnt_q + 4'd1;
            to_d    = TW'(TIMEOUT_TICKS);
        end else if (tick && (cnt_q != 4'd0)) begin
            if (to_q <= TW'(1)) begin
                cnt_d = 4'd0;
                to_d  = '0;
            end else begin
                to_d = to_q - TW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            clk_prev_q  <= 1'b1;
            div_q       <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            to_q        <= '0;
            byte_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            byte_q      <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q  <= {dat_sync_q[0], ps2_data_i};
            div_q       <= tick ? DW'(CLK_DIV - 1) : div_q - DW'(1);
            if (tick) clk_prev_q <= clk_sync_q[1];
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            to_q        <= to_d;
            byte_vld_q  <= frame_end && frame_ok;
            frame_err_q <= frame_end && !frame_ok;
            if (frame_end) byte_q <= shift_d[8:1];
        end
    end

    assign byte_vld_o  = byte_vld_q;
    assign byte_o      = byte_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: rtl/ps2_key_scanner.sv
// PS/2 key scanner: prefix-aware decoder, per-key held state and event FIFO.
// Define TYPEMATIC_FILTER_EN to suppress auto-repeat makes of keys already held.
//
// state      | meaning
// ST_IDLE    | no prefix pending
// ST_EXT     | E0 seen
// ST_BRK     | F0 seen
// ST_EXT_BRK | E0 F0 seen
// ST_PAUSE   | inside E1 Pause sequence, skip_q bytes left
module ps2_key_scanner
    import ps2_key_pkg::*;
#(
    parameter int CLK_DIV       = 250,
    parameter int TIMEOUT_TICKS = 4000,
    parameter int NUM_KEYS      = 10,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                PS2_CLK,
    input  logic                PS2_DATA,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_held,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [7:0]          evt_code,
    output logic                evt_ext,
    output logic                evt_brk,
    output logic                frame_err,
    output logic                overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic       byte_vld;
    logic [7:0] rx_byte;

    ps2_frame_rx #(
        .CLK_DIV       (CLK_DIV),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_rx (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .ps2_clk_i   (PS2_CLK),
        .ps2_data_i  (PS2_DATA),
        .byte_vld_o  (byte_vld),
        .byte_o      (rx_byte),
        .frame_err_o (frame_err)
    );

    dec_state_e state_q, state_d;
    logic [2:0] skip_q, skip_d;
    logic       ev_emit, ev_ext, ev_brk;
    logic [7:0] ev_code;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        if (byte_vld) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte == E0)      state_d = ST_EXT;
                    else if (rx_byte == F0) state_d = ST_BRK;
                    else if (rx_byte == E1) begin
                        state_d = ST_PAUSE;
                        skip_d  = PAUSE_SKIP;
                    end
                end
                ST_EXT:   state_d = (rx_byte == F0) ? ST_EXT_BRK : ST_IDLE;
                ST_PAUSE: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) state_d = ST_IDLE;
                end
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ev_emit = 1'b0;
        ev_code = rx_byte;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        if (byte_vld) begin
            case (state_q)
                ST_IDLE:    ev_emit = (rx_byte != E0) && (rx_byte != F0) && (rx_byte != E1);
                ST_EXT: begin
                    ev_emit = (rx_byte != F0);
                    ev_ext  = 1'b1;
                end
                ST_BRK: begin
                    ev_emit = 1'b1;
                    ev_brk  = 1'b1;
                end
                ST_EXT_BRK: begin
                    ev_emit = 1'b1;
                    ev_ext  = 1'b1;
                    ev_brk  = 1'b1;
                end
                ST_PAUSE: begin
                    ev_emit = (skip_q == 3'd1);
                    ev_code = E1;
                end
                default: ev_emit = 1'b0;
            endcase
        end
    end

    logic [NUM_KEYS-1:0] hit, held_q, held_d, press_q, press_d;
    logic                suppress, push;

    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) hit[i] = key_match(key_map(i), ev_code, ev_ext);
    end

`ifdef TYPEMATIC_FILTER_EN
    assign suppress = !ev_brk && |(hit & held_q);
`else
    assign suppress = 1'b0;
`endif
    assign push = ev_emit && !suppress;

    // Pause is a momentary key: it pulses but never latches a held bit
    always_comb begin
        press_d = '0;
        held_d  = held_q;
        if (push && !ev_brk) begin
            press_d = hit;
            if (ev_code != E1) held_d = held_q | hit;
        end else if (ev_emit && ev_brk) begin
            held_d = held_q & ~hit;
        end
    end

    key_evt_t    mem_q [FIFO_DEPTH];
    key_evt_t    head;
    logic [AW:0] wr_q, rd_q;
    logic        ovf_q, empty, full, pop, do_push;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = !empty && evt_ready;
    assign do_push = push && (!full || pop);

    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= '{ev_code, ev_ext, ev_brk};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_q    <= '0;
            rd_q    <= '0;
            ovf_q   <= 1'b0;
            held_q  <= '0;
            press_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            if (push && full && !pop) ovf_q <= 1'b1;
            held_q  <= held_d;
            press_q <= press_d;
        end
    end

    assign head      = mem_q[rd_q[AW-1:0]];
    assign evt_valid = !empty;
    assign evt_code  = empty ? 8'h00 : head.code;
    assign evt_ext   = !empty && head.ext;
    assign evt_brk   = !empty && head.brk;
    assign key_press = press_q;
    assign key_held  = held_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_key_scanner.sv
// Self-checking bench for ps2_key_scanner: directed scenarios plus random keystrokes
// against a keystroke-level model (honours TYPEMATIC_FILTER_EN when defined).
module tb_ps2_key_scanner;
    localparam int CLK_DIV       = 4;
    localparam int TIMEOUT_TICKS = 64;
    localparam int NK            = 10;
    localparam int DEPTH         = 4;
    localparam int HP            = 3 * CLK_DIV;
`ifdef TYPEMATIC_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic          CLK = 1'b0, RESET_N = 1'b0, PS2_CLK = 1'b1, PS2_DATA = 1'b1, evt_ready = 1'b0;
    logic [NK-1:0] key_press, key_held;
    logic          evt_valid, evt_ext, evt_brk, frame_err, overflow;
    logic [7:0]    evt_code;

    ps2_key_scanner #(
        .CLK_DIV(CLK_DIV), .TIMEOUT_TICKS(TIMEOUT_TICKS), .NUM_KEYS(NK), .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
        .key_press(key_press), .key_held(key_held), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_code(evt_code), .evt_ext(evt_ext), .evt_brk(evt_brk),
        .frame_err(frame_err), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    int            total = 0, bad = 0;
    bit            ready_en = 1'b0;
    logic [7:0]    tbl_code [NK] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h55, 8'h4E, 8'h5A, 8'h76, 8'h2D, 8'hE1};
    int            tbl_mode [NK] = '{2, 2, 2, 2, 0, 0, 2, 0, 0, 0};  // 0 must0, 1 must1, 2 either
    logic [7:0]    pool [13] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h55, 8'h4E, 8'h5A, 8'h76, 8'h2D,
                                 8'h1C, 8'h14, 8'h77, 8'h29};
    logic [9:0]    model_q [$];
    logic [NK-1:0] exp_held = '0;
    int            exp_press [NK];
    int            got_press [NK];
    int            exp_ferr = 0, got_ferr = 0;
    bit            exp_ovf = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    function automatic bit tbl_hit(input int i, input logic [7:0] c, input bit e);
        return (tbl_code[i] == c) && (tbl_mode[i] == 2 || tbl_mode[i] == int'(e));
    endfunction

    // Keystroke-level model: what one complete event does to the FIFO and key state
    function automatic void model_event(input logic [7:0] c, input bit e, input bit b);
        bit sup = 1'b0;
        if (!b && FILT)
            for (int i = 0; i < NK; i++) if (tbl_hit(i, c, e) && exp_held[i]) sup = 1'b1;
        if (sup) return;
        if (model_q.size() < DEPTH) model_q.push_back({c, e, b});
        else exp_ovf = 1'b1;
        for (int i = 0; i < NK; i++) begin
            if (tbl_hit(i, c, e)) begin
                if (!b) begin
                    exp_press[i]++;
                    if (i != 9) exp_held[i] = 1'b1;
                end else begin
                    exp_held[i] = 1'b0;
                end
            end
        end
    endfunction

    task automatic ps2_bit(input logic b);
        repeat (HP / 2) @(negedge CLK);
        PS2_DATA = b;
        repeat (HP / 2) @(negedge CLK);
        PS2_CLK = 1'b0;
        repeat (HP) @(negedge CLK);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
        for (int k = 0; k < nbits; k++) ps2_bit(f[k]);
        repeat (HP) @(negedge CLK);
        PS2_DATA = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
    endtask

    task automatic send_pause();
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    endtask

    task automatic key_group(input int kind, input logic [7:0] c);
        case (kind)
            0: begin model_event(c, 1'b0, 1'b0); send(c); end
            1: begin model_event(c, 1'b1, 1'b0); send(8'hE0); send(c); end
            2: begin model_event(c, 1'b0, 1'b1); send(8'hF0); send(c); end
            3: begin model_event(c, 1'b1, 1'b1); send(8'hE0); send(8'hF0); send(c); end
            4: begin model_event(8'hE1, 1'b0, 1'b0); send_pause(); end
            default: begin exp_ferr++; send_bits(c, 1'b1, 11); end
        endcase
    endtask

    task automatic checkpoint(input string nm);
        repeat (8) @(negedge CLK);
        chk({nm, ":held"}, 32'(key_held), 32'(exp_held));
        for (int i = 0; i < NK; i++) chk($sformatf("%s:press%0d", nm, i), got_press[i], exp_press[i]);
        chk({nm, ":ferr"}, got_ferr, exp_ferr);
        chk({nm, ":ovf"}, 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((model_q.size() != 0 || evt_valid) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        chk({nm, ":left"}, model_q.size(), 0);
        chk({nm, ":valid"}, 32'(evt_valid), 0);
    endtask

    // Per-cycle monitor and consumer: counts pulses, checks the FIFO head against the model
    initial begin
        forever begin
            @(negedge CLK);
            for (int i = 0; i < NK; i++) if (key_press[i]) got_press[i]++;
            if (frame_err) got_ferr++;
            if (!evt_valid) chk("idle_head_zero", {22'b0, evt_code, evt_ext, evt_brk}, 32'h0);
            evt_ready = ready_en && ($urandom_range(0, 1) == 1);
            if (evt_valid && evt_ready) begin
                if (model_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: actual=%0h required=none",
                             {evt_code, evt_ext, evt_brk});
                end else begin
                    chk("event", {22'b0, evt_code, evt_ext, evt_brk}, {22'b0, model_q.pop_front()});
                end
            end
        end
    end

    initial begin
        repeat (95000) @(posedge CLK);
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p4;
        for (int i = 0; i < NK; i++) begin
            exp_press[i] = 0;
            got_press[i] = 0;
        end
        repeat (5) @(negedge CLK);
        chk("rst_press", 32'(key_press), 0);
        chk("rst_held", 32'(key_held), 0);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_head", {22'b0, evt_code, evt_ext, evt_brk}, 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_ovf", 32'(overflow), 0);
        RESET_N  = 1'b1;
        ready_en = 1'b1;
        repeat (5) @(negedge CLK);

        model_event(8'h75, 1'b0, 1'b0);
        chk("pin_make75", 32'(model_q[$]), 32'h1D4);
        send(8'h75);
        checkpoint("make75");
        chk("make75_held_lit", 32'(key_held), 32'h1);
        chk("make75_press_lit", got_press[0], 1);

        model_event(8'h75, 1'b1, 1'b0);
        send(8'hE0); send(8'h75);
        checkpoint("ext_make75");
        chk("ext_make75_held0", 32'(key_held[0]), 1);
        model_event(8'h75, 1'b1, 1'b1);
        chk("pin_ext_brk75", 32'(model_q[$]), 32'h1D7);
        send(8'hE0); send(8'hF0); send(8'h75);
        checkpoint("ext_brk75");
        chk("ext_brk75_held0", 32'(key_held[0]), 0);

        model_event(8'hE1, 1'b0, 1'b0);
        chk("pin_pause", 32'(model_q[$]), 32'h384);
        send_pause();
        checkpoint("pause");
        chk("pause_press9_lit", got_press[9], 1);

        exp_ferr++;
        send_bits(8'h5A, 1'b1, 11);
        checkpoint("bad_parity");
        chk("bad_parity_ferr_lit", got_ferr, 1);
        model_event(8'h5A, 1'b0, 1'b0);
        send(8'h5A);
        checkpoint("good_5a");

        send_bits(8'h76, 1'b0, 6);
        repeat ((TIMEOUT_TICKS + 4) * CLK_DIV) @(negedge CLK);
        model_event(8'h76, 1'b0, 1'b0);
        send(8'h76);
        checkpoint("timeout");
        chk("timeout_no_ferr_lit", got_ferr, 1);

        drain("pre_reset");
        send_bits(8'h74, 1'b0, 5);
        RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        model_q.delete();
        exp_held = '0;
        exp_ovf  = 1'b0;
        RESET_N  = 1'b1;
        repeat (3) @(negedge CLK);
        model_event(8'h74, 1'b0, 1'b0);
        send(8'h74);
        checkpoint("mid_reset");

        drain("pre_ovf");
        ready_en = 1'b0;
        repeat (4) @(negedge CLK);
        for (int k = 0; k <= DEPTH; k++) begin
            model_event(8'h1C, 1'b0, 1'b0);
            send(8'h1C);
        end
        checkpoint("overflow");
        chk("overflow_lit", 32'(overflow), 1);
        chk("overflow_valid", 32'(evt_valid), 1);
        chk("pin_ovf_depth", model_q.size(), DEPTH);
        ready_en = 1'b1;
        drain("post_ovf");

        p4 = got_press[4];
        for (int k = 0; k < 3; k++) begin
            model_event(8'h55, 1'b0, 1'b0);
            send(8'h55);
        end
        checkpoint("typematic");
        chk("typematic_press4_lit", got_press[4] - p4, FILT ? 1 : 3);
        model_event(8'h55, 1'b0, 1'b1);
        send(8'hF0); send(8'h55);
        checkpoint("typematic_release");

        for (int g = 0; g < 30; g++) begin
            key_group(int'($urandom_range(0, 5)), pool[$urandom_range(0, 12)]);
            checkpoint($sformatf("rand%0d", g));
        end

        drain("final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_scanner.md
Name: ps2_key_scanner

Overview:
Parametrised PS/2 keyboard receiver and decoder. It replaces the single-byte key decoder and adds:
- prefix-aware decoding: E0 extended, F0 break, and the E1 Pause sequence;
- per-key held state;
- a buffered event stream for the game controller.

It sits between the board PS/2 pins and the game FSM/menu logic.

Parameters:
CLK_DIV, 250, CLK cycles per PS/2 sample tick (range 2..65535).
TIMEOUT_TICKS, 4000, sample ticks without a falling PS2_CLK edge before a partial frame is discarded.
NUM_KEYS, 10, number of key-map entries driving key_press/key_held (range 1..16).
FIFO_DEPTH, 4, event FIFO entries (power of two, at least 2).

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
PS2_CLK  in  1  raw keyboard clock, asynchronous
PS2_DATA  in  1  raw keyboard data, asynchronous
key_press  out  NUM_KEYS  one-CLK pulse per make of mapped key i
key_held  out  NUM_KEYS  level: key i currently down
evt_valid  out  1  event FIFO not empty
evt_ready  in  1  consumer pop; pop occurs when evt_valid && evt_ready
evt_code  out  8  event scan code (8'hE1 for Pause)
evt_ext  out  1  event had E0 prefix
evt_brk  out  1  event is a break (release)
frame_err  out  1  one-CLK pulse on start/stop/parity failure
overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset: all outputs 0, FIFO empty, decoder state IDLE, bit counter 0, tick divider 0. Asserting RESET_N low mid-frame discards the frame. Clock and reset ports are CLK and RESET_N; reset is asynchronous, active-low.
- PS2_CLK and PS2_DATA pass through 2-flop synchronisers.
- A tick pulses for 1 CLK every CLK_DIV cycles. All frame logic advances only on ticks.
- Falling edge = synchronised PS2_CLK was 1 at the previous tick and is 0 now. On each falling edge, shift PS2_DATA in LSB-first and increment the 4-bit counter.
- Frame check: at count 11, clear the counter. The frame is valid when start=0, stop=1, and data[7:0]^parity = 1 (odd parity). A valid frame pulses byte_vld with the data byte. An invalid frame pulses frame_err, emits no byte and leaves the decoder state unchanged.
- Timeout: with count 1..10 and TIMEOUT_TICKS ticks since the last falling edge, clear the counter silently (no frame_err).
- Decoder FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE. Transitions on byte_vld:
  - IDLE: E0 goes to EXT; F0 goes to BRK; E1 goes to PAUSE with skip counter 7; any other byte emits make{code,ext=0} and stays IDLE.
  - EXT: F0 goes to EXT_BRK; any other byte emits make{code,ext=1} and goes to IDLE.
  - BRK: emits break{code,ext=0}, goes to IDLE.
  - EXT_BRK: emits break{code,ext=1}, goes to IDLE.
  - PAUSE: decrement the skip counter. When it reaches 0, emit make{8'hE1,0} and go to IDLE. Pause has no break event.
- Key map: a packaged table gives each entry {code, ext_mode}. ext_mode is MUST0, MUST1 or DONTCARE. An emitted event matches entry i when the code is equal and the ext flag satisfies ext_mode.
  - Make: key_press[i] pulses and key_held[i] is set.
  - Break: key_held[i] is cleared.
  - Pause sets no held bit.
- Latency: key_press and FIFO push occur on the CLK edge after the byte_vld that completes the event. evt_valid rises 1 CLK later.
- FIFO: every emitted event is pushed, mapped or not. When full, a push without a simultaneous pop drops the event and sets overflow. Push and pop in the same cycle while full: both succeed. Pop while empty is ignored. evt_code, evt_ext and evt_brk present the head entry and are 0 when empty.

Optional Feature:
TYPEMATIC_FILTER_EN
- Defined: a make for entry i while key_held[i]=1 produces no key_press pulse and no FIFO push (auto-repeat suppressed). Unmapped codes are always pushed.
- Undefined: every typematic make pulses key_press and is pushed.

Decomposition:
- Package ps2_key_pkg holds:
  - prefix constants E0, F0, E1;
  - the ext_mode enum;
  - key index constants: UP=0, DOWN=1, LEFT=2, RIGHT=3, PLUS=4, MINUS=5, ENTER=6, ESCAPE=7, RESET=8, PAUSE=9;
  - the default key table: 75/DC, 72/DC, 6B/DC, 74/DC, 55/0, 4E/0, 5A/DC, 76/0, 2D/0, E1/0.
- Sub-module ps2_frame_rx holds the synchronisers, tick divider, shifter, frame check and timeout, and outputs byte_vld, byte and frame_err.

Test Plan:
- Frame 8'h75 (parity 0) at 12.5 kHz PS/2 clock, CLK_DIV=250 -> key_press[0] pulses once, key_held[0]=1, event {75,0,0}.
- Bytes E0 75, then E0 F0 75 -> event {75,1,0} with key_held[0]=1, then event {75,1,1} with key_held[0]=0.
- E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,0,0}, key_press[9] pulses, no other key_press pulses.
- 8'h5A sent with wrong parity -> frame_err pulses, no event; a following good 5A -> event {5A,0,0}.
- 6 bits then idle for 4000 ticks, then a full 8'h76 -> partial frame discarded, no frame_err, event {76,0,0}.
- evt_ready=0 and FIFO_DEPTH+1 makes of 8'h1C -> first 4 events retained, overflow=1; with TYPEMATIC_FILTER_EN and 8'h55 repeated 3x -> one key_press[4] pulse and one event.
